store_write_buffer: RTL and testbench

- Sits directly downstream of the store data queue and consumes the committed stores it issues (one per cycle at most).
- Buffers those stores in a small in-order FIFO and converts each one to a word-aligned data-memory write with byte enables.
- Drains the FIFO through a request/ack memory handshake, one outstanding write at a time.
- Reports drain-empty status to the LSU for fence and flush sequencing.

---
 rtl/store_write_buffer.sv | 78 +++++++
 tb/tb_store_write_buffer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/store_write_buffer.sv
// store_write_buffer: in-order committed-store FIFO draining word-aligned byte-enabled writes over a req/ack port
module store_write_buffer #(
  parameter int SWB_ENTRIES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [1:0]            in_size,
  output logic                  in_rdy,
  output logic                  misalign_err,
  output logic                  mem_req_vld,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  output logic [3:0]            mem_req_be,
  input  logic                  mem_req_rdy,
  input  logic                  mem_resp_vld,
  output logic                  swb_empty,
  output logic [$clog2(SWB_ENTRIES < 2 ? 2 : SWB_ENTRIES):0] swb_count
);
  localparam int PW = $clog2(SWB_ENTRIES < 2 ? 2 : SWB_ENTRIES);
  localparam int DEPTH = 1 << PW;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [3:0]            be_mem   [DEPTH];
  logic [PW:0] head_q, tail_q, count_q;
  logic [1:0] o;
  logic aligned, push, pop;
  logic [3:0] be;
  assign o = in_addr[1:0];
  assign aligned = (in_size == 2'b00) | (in_size == 2'b01 & ~o[0]) | (in_size == 2'b10 & o == 2'b00);
  assign be = in_size == 2'b00 ? 4'b0001 << o : in_size == 2'b01 ? 4'b0011 << o : 4'b1111;
  assign in_rdy = count_q != (PW+1)'(DEPTH);
  assign push = in_vld & in_rdy & aligned;
  assign pop = (state_q == WAIT_ACK) & mem_resp_vld;
  assign swb_empty = (count_q == '0) & (state_q == IDLE);
  assign swb_count = count_q;
  always_comb begin
    state_d = state_q == IDLE ? (count_q != '0 ? REQ : IDLE) :
              state_q == REQ  ? (mem_req_rdy ? WAIT_ACK : REQ) :
                                (mem_resp_vld ? IDLE : WAIT_ACK);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      misalign_err <= 1'b0;
      mem_req_vld <= 1'b0;
      mem_req_addr <= '0;
      mem_req_wdata <= '0;
      mem_req_be <= '0;
    end else begin
      if (push) begin
        addr_mem[tail_q[PW-1:0]] <= {in_addr[ADDR_WIDTH-1:2], 2'b00};
        data_mem[tail_q[PW-1:0]] <= in_data << {o, 3'b000};
        be_mem[tail_q[PW-1:0]] <= be;
      end
      tail_q <= tail_q + (PW+1)'(push);
      head_q <= head_q + (PW+1)'(pop);
      count_q <= count_q + (PW+1)'(push) - (PW+1)'(pop);
      state_q <= state_d;
      misalign_err <= in_vld & in_rdy & ~aligned;
      mem_req_vld <= state_d == REQ;
      if (state_q == IDLE && state_d == REQ) begin
        mem_req_addr <= addr_mem[head_q[PW-1:0]];
        mem_req_wdata <= data_mem[head_q[PW-1:0]];
        mem_req_be <= be_mem[head_q[PW-1:0]];
      end
    end
  end
endmodule

// File: tb/tb_store_write_buffer.sv
// tb_store_write_buffer: directed self-checking bench for store_write_buffer
module tb_store_write_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_vld = 1'b0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_data = '0;
  logic [1:0] in_size = '0;
  logic in_rdy, misalign_err, mem_req_vld, swb_empty;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0] mem_req_be;
  logic mem_req_rdy = 1'b0;
  logic mem_resp_vld = 1'b0;
  logic [2:0] swb_count;
  int checks = 0;
  int errors = 0;
  store_write_buffer dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_addr(in_addr), .in_data(in_data),
    .in_size(in_size), .in_rdy(in_rdy), .misalign_err(misalign_err),
    .mem_req_vld(mem_req_vld), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_req_be(mem_req_be), .mem_req_rdy(mem_req_rdy), .mem_resp_vld(mem_resp_vld),
    .swb_empty(swb_empty), .swb_count(swb_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic acc;
    acc = in_vld & in_rdy;
    @(posedge clk);
    #1;
    if (acc) in_vld = 1'b0;
  endtask
  task automatic present(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    in_addr = a;
    in_data = d;
    in_size = s;
    in_vld = 1'b1;
  endtask
  task automatic wait_req();
    for (int i = 0; i < 10 && !mem_req_vld; i++) tick();
    chk("req_vld_seen", {31'b0, mem_req_vld}, 32'd1);
  endtask
  task automatic send(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                      input logic [31:0] ea, input logic [3:0] ebe, input logic [31:0] ed);
    mem_req_rdy = 1'b1;
    present(a, d, s);
    tick();
    chk({tag, "_count1"}, {29'b0, swb_count}, 32'd1);
    chk({tag, "_vld_early"}, {31'b0, mem_req_vld}, 32'd0);
    tick();
    chk({tag, "_vld"}, {31'b0, mem_req_vld}, 32'd1);
    chk({tag, "_addr"}, mem_req_addr, ea);
    chk({tag, "_be"}, {28'b0, mem_req_be}, {28'b0, ebe});
    chk({tag, "_wdata"}, mem_req_wdata, ed);
    tick();
    chk({tag, "_vld_wait"}, {31'b0, mem_req_vld}, 32'd0);
    mem_resp_vld = 1'b1;
    tick();
    mem_resp_vld = 1'b0;
    chk({tag, "_count0"}, {29'b0, swb_count}, 32'd0);
    chk({tag, "_empty"}, {31'b0, swb_empty}, 32'd1);
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_in_rdy", {31'b0, in_rdy}, 32'd1);
    chk("rst_empty", {31'b0, swb_empty}, 32'd1);
    chk("rst_vld", {31'b0, mem_req_vld}, 32'd0);
    chk("rst_count", {29'b0, swb_count}, 32'd0);
    chk("rst_mis", {31'b0, misalign_err}, 32'd0);
    send("word", 32'h100, 32'hDEADBEEF, 2'b10, 32'h100, 4'b1111, 32'hDEADBEEF);
    send("byte", 32'h203, 32'h000000AB, 2'b00, 32'h200, 4'b1000, 32'hAB000000);
    send("half", 32'h302, 32'h00001234, 2'b01, 32'h300, 4'b1100, 32'h12340000);
    send("byte1", 32'h401, 32'h000000CD, 2'b00, 32'h400, 4'b0010, 32'h0000CD00);
    present(32'h301, 32'h5678, 2'b01);
    tick();
    chk("mis_pulse", {31'b0, misalign_err}, 32'd1);
    chk("mis_count", {29'b0, swb_count}, 32'd0);
    tick();
    chk("mis_drop", {31'b0, misalign_err}, 32'd0);
    chk("mis_vld", {31'b0, mem_req_vld}, 32'd0);
    present(32'h102, 32'h1, 2'b10);
    tick();
    chk("mis_word", {31'b0, misalign_err}, 32'd1);
    present(32'h100, 32'h1, 2'b11);
    tick();
    chk("mis_size3", {31'b0, misalign_err}, 32'd1);
    chk("mis_size3_cnt", {29'b0, swb_count}, 32'd0);
    tick();
    mem_req_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      present(32'h400 + 32'(4 * i), 32'h11111111 * 32'(i + 1), 2'b10);
      tick();
    end
    chk("full_count", {29'b0, swb_count}, 32'd4);
    chk("full_in_rdy", {31'b0, in_rdy}, 32'd0);
    present(32'h410, 32'h55555555, 2'b10);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_hold_vld", {31'b0, in_vld}, 32'd1);
      chk("full_hold_cnt", {29'b0, swb_count}, 32'd4);
      chk("stable_vld", {31'b0, mem_req_vld}, 32'd1);
      chk("stable_addr", mem_req_addr, 32'h400);
      chk("stable_wdata", mem_req_wdata, 32'h11111111);
      chk("stable_mis", {31'b0, misalign_err}, 32'd0);
    end
    mem_req_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_req();
      chk("drain_addr", mem_req_addr, 32'h400 + 32'(4 * k));
      chk("drain_wdata", mem_req_wdata, 32'h11111111 * 32'(k + 1));
      chk("drain_be", {28'b0, mem_req_be}, 32'hF);
      tick();
      chk("drain_wait", {31'b0, mem_req_vld}, 32'd0);
      mem_resp_vld = 1'b1;
      tick();
      mem_resp_vld = 1'b0;
    end
    chk("drain_in_vld", {31'b0, in_vld}, 32'd0);
    chk("drain_count", {29'b0, swb_count}, 32'd0);
    chk("drain_empty", {31'b0, swb_empty}, 32'd1);
    mem_req_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      present(32'h500 + 32'(4 * i), 32'h0 + 32'(i), 2'b10);
      tick();
    end
    mem_req_rdy = 1'b1;
    wait_req();
    tick();
    chk("mid_wait_vld", {31'b0, mem_req_vld}, 32'd0);
    chk("mid_count", {29'b0, swb_count}, 32'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_count", {29'b0, swb_count}, 32'd0);
    chk("mid_rst_vld", {31'b0, mem_req_vld}, 32'd0);
    mem_resp_vld = 1'b1;
    tick();
    mem_resp_vld = 1'b0;
    chk("late_ack_count", {29'b0, swb_count}, 32'd0);
    chk("late_ack_empty", {31'b0, swb_empty}, 32'd1);
    tick();
    chk("late_ack_vld", {31'b0, mem_req_vld}, 32'd0);
    chk("late_ack_rdy", {31'b0, in_rdy}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
